// File: rtl/fifo_flags_if.sv
// fifo_flags_if: producer/consumer handshake bundle for the fifo_flags buffer.
// master = the block driving writes/reads, slave = the FIFO itself.
interface fifo_flags_if #(
   parameter int WD = 16,
   parameter int CW = 12
);
   logic          wrreq;
   logic [WD-1:0] data;
   logic          rdreq;
   logic          clr_err;
   logic [WD-1:0] q;
   logic [CW-1:0] usedw;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic          overflow;
   logic          underflow;

   modport master (
      output wrreq, data, rdreq, clr_err,
      input  q, usedw, full, empty, almost_full, almost_empty, overflow, underflow
   );

   modport slave (
      input  wrreq, data, rdreq, clr_err,
      output q, usedw, full, empty, almost_full, almost_empty, overflow, underflow
   );
endinterface

// File: rtl/fifo_flags.sv
// fifo_flags: single-clock synchronous FIFO with true SZ-word capacity,
// registered full/empty/almost flags and sticky overflow/underflow errors.
// Define FIFO_FWFT_EN to build the first-word-fall-through variant, where the
// output register holds the head word and counts towards usedw.
module fifo_flags #(
   parameter int SZ = 2048,
   parameter int WD = 16,
   parameter int AF = SZ - 16,
   parameter int AE = 16
) (
   input logic         clk,
   input logic         rst,
   fifo_flags_if.slave bus
);
   localparam int AW = $clog2(SZ);
   localparam int CW = AW + 1;

   logic [WD-1:0] mem [SZ];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] usedw_reg;
   logic [CW-1:0] usedw_next;
   logic [WD-1:0] q_reg;
   logic          full_reg;
   logic          empty_reg;
   logic          af_reg;
   logic          ae_reg;
   logic          ovf_reg;
   logic          unf_reg;

   logic          rd_ok;
   logic          wr_ok;
   logic          mem_pop;
   logic          empty_next;

`ifdef FIFO_FWFT_EN
   logic          qv_reg;
   logic          qv_next;
   logic [CW-1:0] mem_cnt;

   // Refill the output register from memory whenever it is empty or being popped.
   always_comb begin
      mem_cnt    = usedw_reg - CW'(qv_reg);
      rd_ok      = bus.rdreq & qv_reg;
      mem_pop    = (mem_cnt != '0) & (~qv_reg | rd_ok);
      qv_next    = mem_pop | (qv_reg & ~rd_ok);
      empty_next = ~qv_next;
   end

   // Output-valid register: empty in this mode means q is not valid.
   always_ff @(posedge clk) begin
      if (rst) qv_reg <= 1'b0;
      else     qv_reg <= qv_next;
   end
`else
   // Standard mode: a read pops memory straight into q.
   always_comb begin
      rd_ok      = bus.rdreq & ~empty_reg;
      mem_pop    = rd_ok;
      empty_next = (usedw_next == '0);
   end
`endif

   // Write acceptance and next occupancy; a full FIFO still takes a write when a read frees a slot.
   always_comb begin
      wr_ok      = bus.wrreq & (~full_reg | rd_ok);
      usedw_next = usedw_reg;
      if (wr_ok & ~rd_ok)      usedw_next = usedw_reg + CW'(1);
      else if (~wr_ok & rd_ok) usedw_next = usedw_reg - CW'(1);
   end

   // Storage array: no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_ok & ~rst) mem[wr_ptr_reg] <= bus.data;
   end

   // Pointers, occupancy, read register and flags, all derived from next-state usedw.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         usedw_reg  <= '0;
         q_reg      <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
         af_reg     <= 1'b0;
         ae_reg     <= 1'b1;
         ovf_reg    <= 1'b0;
         unf_reg    <= 1'b0;
      end else begin
         if (wr_ok)   wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (mem_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
            q_reg      <= mem[rd_ptr_reg];
         end
         usedw_reg <= usedw_next;
         full_reg  <= (usedw_next == CW'(SZ));
         empty_reg <= empty_next;
         af_reg    <= (usedw_next >= CW'(AF));
         ae_reg    <= (usedw_next <= CW'(AE));
         // New error events win over a coincident clear.
         ovf_reg   <= (ovf_reg & ~bus.clr_err) | (bus.wrreq & ~wr_ok);
         unf_reg   <= (unf_reg & ~bus.clr_err) | (bus.rdreq & ~rd_ok);
      end
   end

   assign bus.q            = q_reg;
   assign bus.usedw        = usedw_reg;
   assign bus.full         = full_reg;
   assign bus.empty        = empty_reg;
   assign bus.almost_full  = af_reg;
   assign bus.almost_empty = ae_reg;
   assign bus.overflow     = ovf_reg;
   assign bus.underflow    = unf_reg;
endmodule

// File: doc/fifo_flags.md
# fifo_flags

Parametrised single-clock synchronous FIFO for the sample and command datapaths, the general-purpose buffer between producer/consumer blocks running on the same clock. It extends the basic FIFO with a true SZ-word capacity, guarded read/write, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. Optional first-word-fall-through output mode.

## Interface
- SZ, 2048: depth in words; power of two, ≥4
- WD, 16: data width in bits
- AF, SZ-16: almost_full threshold in words, 1 ≤ AF ≤ SZ
- AE, 16: almost_empty threshold in words, 0 ≤ AE < SZ
- Derived: AW = clog2(SZ) (address width), CW = AW+1 (count width)
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- wrreq  in  1  write request
- data  in  WD  write data
- rdreq  in  1  read request (pop)
- q  out  WD  read data
- usedw  out  CW  words held, 0..SZ
- full  out  1  usedw == SZ
- empty  out  1  no word available to read
- almost_full  out  1  usedw ≥ AF
- almost_empty  out  1  usedw ≤ AE
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow/underflow

## Operation
- Reset values: usedw=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, q=0; read/write pointers reset to 0. Memory contents are not reset.
- Write accept: wr_ok = wrreq & (!full | rd_ok). Read accept: rd_ok = rdreq & !empty.
- Write while full with no accepted read: data dropped, pointers and usedw unchanged, overflow set.
- Read while empty: ignored, q holds its value, underflow set.
- Simultaneous accepted read and write: both performed, usedw unchanged. This includes the full case, where the write lands in the slot freed that cycle.
- Write into empty FIFO with rdreq also high: write accepted, read rejected, underflow set.
- Pointers are AW bits and wrap modulo SZ. usedw is CW bits so that SZ is representable.
- All flags are registered and computed from the next-state usedw. They are always consistent with usedw in the same cycle.
- overflow/underflow hold until clr_err or rst. If clr_err coincides with a new error event, the flag stays set (set wins).
- Reset asserted mid-operation: all state is discarded next edge, and any wrreq/rdreq in the reset cycle is ignored.

## Timing
- Standard mode: q updates on the edge that accepts rdreq, so data is valid the cycle after rdreq is sampled. Read latency is 1.
- Write-to-empty deassert: wrreq sampled at edge k → empty=0 and usedw=1 after edge k.
- full, almost_* and usedw change on the same edge as the accepting operation.
- No combinational path from wrreq/rdreq to any output.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - q presents the head word whenever empty=0; rdreq pops it, and the next word (if any) appears after that edge.
  - The output register counts in usedw, and total capacity remains SZ.
  - Write into empty FIFO sampled at edge k → q=data, empty=0 after edge k+1.
  - usedw increments after edge k; full/almost_* track usedw.
  - empty means "q not valid", so empty may be 0 one cycle later than usedw becomes nonzero.
- Undefined: standard mode as above, with empty = (usedw == 0).

## Test plan
- SZ=16, WD=8, AF=12, AE=2, standard mode: reset, write 0x01..0x10 back-to-back → full=1 and usedw=16 after 16th edge; almost_full rises with usedw=12; almost_empty falls with usedw=3.
- From full, wrreq with data 0xAA, rdreq=0 → overflow=1, usedw stays 16. Then read 16 words → q sequence 0x01..0x10 with 1-cycle latency, and 0xAA is never read.
- From full, wrreq=rdreq=1 for 20 cycles → usedw stays 16; q returns words in order; no overflow.
- Empty FIFO, rdreq=1 → underflow=1, q unchanged. Pulse clr_err → underflow=0 next cycle. clr_err together with a new empty read → underflow stays 1.
- Write 5 words, assert rst for one cycle with wrreq=1 → all outputs at reset values. A subsequent write/read of 0x5A returns 0x5A.
- FIFO_FWFT_EN: write 0x33 at edge k into empty → q=0x33, empty=0 after edge k+1. rdreq then → empty=1, usedw=0. Fill to 16 → full=1.
